reset_seq: RTL and testbench

//  - Receiving end of the board reset: takes the synchronous active-high system reset and releases downstream

---
 rtl/reset_seq_pkg.sv | 26 ++
 rtl/reset_seq_timer.sv | 33 +++
 rtl/reset_seq.sv | 191 +++++++++++++++++++
 tb/tb_reset_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and width helpers.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Ceiling log2 for elaboration-time widths; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  // Width of a stage index; never narrower than one bit so a single-stage build still has a port.
  function automatic int stage_w(input int nstage);
    return (nstage > 32'sd1) ? clog2(nstage) : 32'sd1;
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Shared CW-bit interval counter for the reset sequencer; used for both the
// hold delay before a release and the ready timeout after it.
module reset_seq_timer
  import reset_seq_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] term,
  output logic          expired
);

  logic [CW-1:0] cnt_r;

  // Counter register: clear wins over enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == term);

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: releases NSTAGE active-low stage resets one at a time,
// HOLD cycles apart, and raises a sticky fault on a ready timeout or a ready drop.
// Optional feature macro: RESET_SEQ_RETRY_EN (one retry of a stage that times out).
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NSTAGE  = 3,
  parameter int HOLD    = 16,
  parameter int TIMEOUT = 1000,
  parameter int CW      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NSTAGE-1:0]            stage_ready,
  output logic [NSTAGE-1:0]            stage_rst_n,
  output logic                         all_ready,
  output logic                         fault,
  output logic [stage_w(NSTAGE)-1:0]   fault_stage
);

  localparam int SW = stage_w(NSTAGE);
  localparam logic [CW-1:0] HOLD_TERM = CW'(HOLD - 32'sd1);
  localparam logic [CW-1:0] WAIT_TERM = CW'(TIMEOUT - 32'sd1);
  localparam logic [SW-1:0] LAST_K    = SW'(NSTAGE - 32'sd1);

  state_t            state_r, state_nxt;
  logic [SW-1:0]     k_r, k_nxt;
  logic [NSTAGE-1:0] rst_n_r, rst_n_nxt;
  logic              all_ready_r, all_ready_nxt;
  logic              fault_r, fault_nxt;
  logic [SW-1:0]     fault_stage_r, fault_stage_nxt;
  logic [SW-1:0]     drop_idx;
  logic              tmr_clr, tmr_en, tmr_expired;
  logic [CW-1:0]     tmr_term;
`ifdef RESET_SEQ_RETRY_EN
  logic              retry_r, retry_nxt;
`endif

  // Stages strictly below idx stay released when a fault is taken.
  function automatic logic [NSTAGE-1:0] below_mask(input logic [SW-1:0] idx);
    logic [NSTAGE-1:0] m;
    m = {NSTAGE{1'b0}};
    for (int i = 0; i < NSTAGE; i++) begin
      if (i < int'(idx)) m[i] = 1'b1;
      else               m[i] = 1'b0;
    end
    return m;
  endfunction

  reset_seq_timer #(.CW(CW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .term    (tmr_term),
    .expired (tmr_expired)
  );

  // Lowest stage whose ready has dropped (only meaningful while any bit is low).
  always_comb begin
    drop_idx = {SW{1'b0}};
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (!stage_ready[i]) drop_idx = SW'(i);
      else                 drop_idx = drop_idx;
    end
  end

  // Next-state, next-output and timer control for the sequencing FSM.
  always_comb begin
    state_nxt       = state_r;
    k_nxt           = k_r;
    rst_n_nxt       = rst_n_r;
    all_ready_nxt   = all_ready_r;
    fault_nxt       = fault_r;
    fault_stage_nxt = fault_stage_r;
    tmr_clr         = 1'b0;
    tmr_en          = 1'b0;
    tmr_term        = HOLD_TERM;
`ifdef RESET_SEQ_RETRY_EN
    retry_nxt       = retry_r;
`endif
    case (state_r)
      ST_HOLD: begin
        tmr_term = HOLD_TERM;
        if (tmr_expired) begin
          rst_n_nxt[k_r] = 1'b1;
          tmr_clr        = 1'b1;
          state_nxt      = ST_WAIT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_WAIT: begin
        tmr_term = WAIT_TERM;
        // Ready is checked before the timeout so a same-edge ready wins.
        if (stage_ready[k_r]) begin
          tmr_clr = 1'b1;
`ifdef RESET_SEQ_RETRY_EN
          retry_nxt = 1'b0;
`endif
          if (k_r == LAST_K) begin
            all_ready_nxt = 1'b1;
            state_nxt     = ST_DONE;
          end else begin
            k_nxt     = k_r + SW'(1'b1);
            state_nxt = ST_HOLD;
          end
        end else if (tmr_expired) begin
          tmr_clr = 1'b1;
`ifdef RESET_SEQ_RETRY_EN
          if (!retry_r) begin
            retry_nxt      = 1'b1;
            rst_n_nxt[k_r] = 1'b0;
            state_nxt      = ST_HOLD;
          end else begin
            fault_nxt       = 1'b1;
            fault_stage_nxt = k_r;
            rst_n_nxt       = below_mask(k_r);
            all_ready_nxt   = 1'b0;
            state_nxt       = ST_FAULT;
          end
`else
          fault_nxt       = 1'b1;
          fault_stage_nxt = k_r;
          rst_n_nxt       = below_mask(k_r);
          all_ready_nxt   = 1'b0;
          state_nxt       = ST_FAULT;
`endif
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DONE: begin
        tmr_clr   = 1'b1;
        rst_n_nxt = {NSTAGE{1'b1}};
        if (!(&stage_ready)) begin
          fault_nxt       = 1'b1;
          fault_stage_nxt = drop_idx;
          rst_n_nxt       = below_mask(drop_idx);
          all_ready_nxt   = 1'b0;
          state_nxt       = ST_FAULT;
        end else begin
          all_ready_nxt = 1'b1;
        end
      end
      ST_FAULT: begin
        tmr_clr   = 1'b1;
        rst_n_nxt = below_mask(fault_stage_r);
      end
      default: begin
        tmr_clr         = 1'b1;
        fault_nxt       = 1'b1;
        fault_stage_nxt = {SW{1'b0}};
        rst_n_nxt       = {NSTAGE{1'b0}};
        all_ready_nxt   = 1'b0;
        state_nxt       = ST_FAULT;
      end
    endcase
  end

  // State, stage index and output registers; rst restarts the whole sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_HOLD;
      k_r           <= {SW{1'b0}};
      rst_n_r       <= {NSTAGE{1'b0}};
      all_ready_r   <= 1'b0;
      fault_r       <= 1'b0;
      fault_stage_r <= {SW{1'b0}};
`ifdef RESET_SEQ_RETRY_EN
      retry_r       <= 1'b0;
`endif
    end else begin
      state_r       <= state_nxt;
      k_r           <= k_nxt;
      rst_n_r       <= rst_n_nxt;
      all_ready_r   <= all_ready_nxt;
      fault_r       <= fault_nxt;
      fault_stage_r <= fault_stage_nxt;
`ifdef RESET_SEQ_RETRY_EN
      retry_r       <= retry_nxt;
`endif
    end
  end

  assign stage_rst_n = rst_n_r;
  assign all_ready   = all_ready_r;
  assign fault       = fault_r;
  assign fault_stage = fault_stage_r;

endmodule

// File: tb/tb_reset_seq.sv
// Testbench for reset_seq (NSTAGE=3, HOLD=4, TIMEOUT=20).
// Edge e of a test is the e-th rising edge after rst is sampled low (first is edge 0).
module tb_reset_seq;

  localparam int NSTAGE  = 3;
  localparam int HOLD    = 4;
  localparam int TIMEOUT = 20;
  localparam int CW      = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] stage_ready = 3'b000;
  logic [2:0] stage_rst_n;
  logic       all_ready;
  logic       fault;
  logic [1:0] fault_stage;

  reset_seq #(.NSTAGE(NSTAGE), .HOLD(HOLD), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .stage_ready (stage_ready),
    .stage_rst_n (stage_rst_n),
    .all_ready   (all_ready),
    .fault       (fault),
    .fault_stage (fault_stage)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] rst_n;
    logic       ar;
    logic       f;
    logic [1:0] fs;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   base   = 0;

  function automatic int E(input int e);
    return base + e + 1;
  endfunction

  task automatic push(input int c, input logic [2:0] rn, input logic ar,
                      input logic f, input logic [1:0] fs, input string nm);
    exp_t x;
    x.cyc = c; x.rst_n = rn; x.ar = ar; x.f = f; x.fs = fs; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drive(input int c, input logic [2:0] v);
    wait_until(c);
    stage_ready = v;
  endtask

  // rst high for n edges with all ready bits low; base marks the cycle before edge 0.
  task automatic do_reset(input int n, input string nm);
    @(negedge clk);
    rst = 1'b1;
    stage_ready = 3'b000;
    push(cyc + 1, 3'b000, 1'b0, 1'b0, 2'd0, nm);
    repeat (n) @(negedge clk);
    rst = 1'b0;
    base = cyc;
  endtask

  // Monitor: compares DUT outputs against every expectation that has come due.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        cur = sb.pop_front();
        checks++;
        if (cur.cyc == cyc && stage_rst_n === cur.rst_n && all_ready === cur.ar &&
            fault === cur.f && fault_stage === cur.fs) begin
          passes++;
        end else begin
          $display("FAIL %s at cyc %0d (due %0d): got rst_n=%b all_ready=%b fault=%b fault_stage=%0d, want rst_n=%b all_ready=%b fault=%b fault_stage=%0d",
                   cur.name, cyc, cur.cyc, stage_rst_n, all_ready, fault, fault_stage,
                   cur.rst_n, cur.ar, cur.f, cur.fs);
        end
      end
    end
  end

  initial begin
    // 1: nominal sequence, then 5: drop of stage 0 while DONE.
    do_reset(5, "t1_reset");
    push(E(2),  3'b000, 1'b0, 1'b0, 2'd0, "t1_before_rel0");
    push(E(3),  3'b001, 1'b0, 1'b0, 2'd0, "t1_rel0");
    push(E(8),  3'b001, 1'b0, 1'b0, 2'd0, "t1_before_rel1");
    push(E(9),  3'b011, 1'b0, 1'b0, 2'd0, "t1_rel1");
    push(E(14), 3'b011, 1'b0, 1'b0, 2'd0, "t1_before_rel2");
    push(E(15), 3'b111, 1'b0, 1'b0, 2'd0, "t1_rel2");
    push(E(16), 3'b111, 1'b0, 1'b0, 2'd0, "t1_before_done");
    push(E(17), 3'b111, 1'b1, 1'b0, 2'd0, "t1_done");
    push(E(20), 3'b111, 1'b1, 1'b0, 2'd0, "t5_still_done");
    push(E(21), 3'b000, 1'b0, 1'b1, 2'd0, "t5_drop0");
    push(E(25), 3'b000, 1'b0, 1'b1, 2'd0, "t5_sticky");
    drive(E(4),  3'b001);
    drive(E(10), 3'b011);
    drive(E(16), 3'b111);
    drive(E(20), 3'b110);
    drive(E(22), 3'b111);
    wait_until(E(25));

    // 2: stage 1 never ready; early ready of unreleased stage 2 is ignored.
    do_reset(2, "t2_reset");
    push(E(28), 3'b011, 1'b0, 1'b0, 2'd0, "t2_before_timeout");
    push(E(29), 3'b001, 1'b0, 1'b1, 2'd1, "t2_timeout1");
    push(E(40), 3'b001, 1'b0, 1'b1, 2'd1, "t2_sticky");
    drive(E(4), 3'b101);
    wait_until(E(40));

    // 3: stage 2 ready on the exact timeout edge.
    do_reset(2, "t3_reset");
    push(E(34), 3'b111, 1'b0, 1'b0, 2'd0, "t3_before_edge");
    push(E(35), 3'b111, 1'b1, 1'b0, 2'd0, "t3_ready_wins");
    drive(E(4),  3'b001);
    drive(E(10), 3'b011);
    drive(E(34), 3'b111);
    wait_until(E(36));

    // 4: rst pulse during WAIT for stage 1 restarts the sequence.
    do_reset(2, "t4_reset");
    push(E(10), 3'b011, 1'b0, 1'b0, 2'd0, "t4_wait1");
    push(E(11), 3'b000, 1'b0, 1'b0, 2'd0, "t4_pulse");
    push(E(14), 3'b000, 1'b0, 1'b0, 2'd0, "t4_before_rerel0");
    push(E(15), 3'b001, 1'b0, 1'b0, 2'd0, "t4_rerel0");
    drive(E(4), 3'b001);
    wait_until(E(10));
    rst = 1'b1;
    wait_until(E(11));
    rst = 1'b0;
    wait_until(E(15));

`ifdef RESET_SEQ_RETRY_EN
    // 6a: stage 0 silent on the first try, ready after the re-hold.
    do_reset(2, "t6a_reset");
    push(E(23), 3'b000, 1'b0, 1'b0, 2'd0, "t6a_retry");
    push(E(27), 3'b001, 1'b0, 1'b0, 2'd0, "t6a_rerel0");
    push(E(35), 3'b011, 1'b0, 1'b0, 2'd0, "t6a_rel1");
    drive(E(28), 3'b001);
    wait_until(E(35));
    // 6b: stage 0 silent on both tries.
    do_reset(2, "t6b_reset");
    push(E(46), 3'b001, 1'b0, 1'b0, 2'd0, "t6b_before_fault");
    push(E(47), 3'b000, 1'b0, 1'b1, 2'd0, "t6b_fault");
    wait_until(E(47));
`endif

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      passes++;
    end else begin
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
